reg_bank_access_ctrl: RTL and testbench
=======================================

Name: reg_bank_access_ctrl

Overview:
- Initiator side of the register_bank_8088 port interface: accepts valid/ready register-access requests using 8088 register encoding and drives the bank's write/read port signals.
- Decodes 8-bit register codes (AL..BH) into bank index plus high/low select.
- Captures read data, extracts bytes for 8-bit reads, and returns a response over a valid/ready handshake.
- Sits between the decode/execute stage and register_bank_8088; keeps access counters.

Parameters:
- CNT_W, 16, width of wr_count / rd_count (wrap-around counters)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_size  in  1  1 = 16-bit, 0 = 8-bit
- req_reg  in  3  8088 register code (write target or read port 1)
- req_reg2  in  3  8088 register code for read port 2 (ignored on writes)
- req_wdata  in  16  write data (byte in [7:0] when req_size = 0)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_write  out  1  response is a write acknowledge
- rsp_data1  out  16  read result, port 1 (zero-extended for 8-bit)
- rsp_data2  out  16  read result, port 2 (zero-extended for 8-bit)
- en_write  out  1  bank write enable
- reg_write  out  3  bank write index
- write_data  out  16  bank write data
- reg_read1  out  3  bank read index 1
- reg_read2  out  3  bank read index 2
- size  out  1  bank size select
- select_high_low  out  1  bank byte select, 1 = high
- read_data1  in  16  bank read data 1 (combinational read)
- read_data2  in  16  bank read data 2 (combinational read)
- wr_count  out  CNT_W  completed writes
- rd_count  out  CNT_W  completed reads

Behaviour:
- Reset (reset = 0, async): state IDLE; every output 0 except req_ready = 1; any in-flight transaction is dropped; en_write deasserts immediately and no bank write occurs.
- FSM states: IDLE, WRITE, READ, RESP.
  - req_ready = 1 only in IDLE.
  - A handshake (req_valid & req_ready at a rising edge) latches all req_* fields and moves to WRITE if req_write = 1, otherwise to READ.
- Decode, 16-bit: bank index = code.
- Decode, 8-bit: bank index = {0, code[1:0]}, select_high_low = code[2]. Codes map to 0 AL, 1 CL, 2 DL, 3 BL, 4 AH, 5 CH, 6 DH, 7 BH.
- WRITE (exactly 1 cycle):
  - en_write = 1; reg_write = decoded index; size = req_size; select_high_low = decoded select (0 when 16-bit).
  - write_data = req_wdata if 16-bit, else {req_wdata[7:0], req_wdata[7:0]}.
  - The bank commits on the edge that ends WRITE. Next state RESP with rsp_write = 1, rsp_data1 = rsp_data2 = 0. wr_count increments on that same edge.
- READ (exactly 1 cycle):
  - reg_read1 / reg_read2 = decoded indices of req_reg / req_reg2; en_write = 0.
  - The edge ending READ captures the response:
    - 16-bit: rsp_dataN = read_dataN.
    - 8-bit: rsp_dataN = {8'h00, byte}, where byte = high half if that port's code[2] = 1, else low half.
  - Next state RESP with rsp_write = 0. rd_count increments on that same edge.
- RESP: rsp_valid = 1 and rsp_* held stable until rsp_ready = 1 at a rising edge, then IDLE. There is no IDLE bypass; a new request is accepted at the earliest in the cycle after the response handshake.
- Latency: request handshake to rsp_valid = 2 edges. Minimum spacing between accepted requests = 3 cycles.
- Bank port signals other than en_write hold their last driven value outside WRITE/READ. en_write is 1 only in WRITE.
- Mixed-size reads use req_size for both ports.
- Read-after-write to the same register in back-to-back transactions must return the new value (guaranteed by the 3-cycle spacing).
- Counters wrap from 2^CNT_W-1 to 0. They are cleared only by reset.

Decomposition:
- Package reg8088_pkg:
  - state enum (IDLE, WRITE, READ, RESP)
  - register-code enums (AX..DI, AL..BH)
  - SIZE_8 = 0, SIZE_16 = 1
- Sub-module reg8088_byte_decode (combinational): code + size -> bank index + select_high_low. Instantiated three times (write, read1, read2).

Test Plan:
- Reset mid-WRITE: assert reset low during WRITE -> en_write drops at once; bank AX unchanged; req_ready = 1; counters 0.
- 16-bit write AX = 16'h1234, then 16-bit read reg=0 reg2=0 -> rsp_data1 = rsp_data2 = 16'h1234; wr_count = 1, rd_count = 1.
- 8-bit write code 4 (AH) data 8'hAB over AX = 16'h1234, then 8-bit read code 4 and code 0 -> rsp_data1 = 16'h00AB, rsp_data2 = 16'h0034; 16-bit read AX = 16'hAB34.
- Response backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and data stable; req_ready = 0; a new req_valid is not accepted until 1 cycle after rsp_ready.
- CNT_W = 2, five writes -> wr_count sequence 1, 2, 3, 0, 1.
- Randomized stream of 200 requests against a reference model of 8 x 16-bit registers -> every rsp_data matches; en_write pulses exactly once per write.

Source files
------------

// File: rtl/reg8088_pkg.sv
// Shared constants and helpers for the 8088 register-bank access controller.
package reg8088_pkg;

  localparam int unsigned STATE_W = 2;

  // Controller states
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_WRITE = 2'd1;
  localparam logic [STATE_W-1:0] ST_READ  = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

  // Access size encoding
  localparam logic SIZE_8  = 1'b0;
  localparam logic SIZE_16 = 1'b1;

  // 16-bit register codes
  typedef enum logic [2:0] {
    AX = 3'd0, CX = 3'd1, DX = 3'd2, BX = 3'd3,
    SP = 3'd4, BP = 3'd5, SI = 3'd6, DI = 3'd7
  } reg16_e;

  // 8-bit register codes
  typedef enum logic [2:0] {
    AL = 3'd0, CL = 3'd1, DL = 3'd2, BL = 3'd3,
    AH = 3'd4, CH = 3'd5, DH = 3'd6, BH = 3'd7
  } reg8_e;

  // Zero-extended byte pick from a 16-bit bank word
  function automatic logic [15:0] extract_byte(input logic [15:0] word, input logic high);
    return high ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/reg8088_byte_decode.sv
// Maps an 8088 register code plus access size to bank index and byte select.
module reg8088_byte_decode
  import reg8088_pkg::*;
(
  input  logic [2:0] code,
  input  logic       size,
  output logic [2:0] index,
  output logic       select_high_low
);

  // 16-bit codes index the bank directly; 8-bit codes split into word + half
  always_comb begin
    index           = code;
    select_high_low = 1'b0;
    if (size == SIZE_8) begin
      index           = {1'b0, code[1:0]};
      select_high_low = code[2];
    end
  end

endmodule

// File: rtl/reg_bank_access_ctrl.sv
// Valid/ready front end for register_bank_8088: one access per request,
// registered bank port signals, registered response, access counters.
module reg_bank_access_ctrl
  import reg8088_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_size,
  input  logic [2:0]       req_reg,
  input  logic [2:0]       req_reg2,
  input  logic [15:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [15:0]      rsp_data1,
  output logic [15:0]      rsp_data2,
  output logic             en_write,
  output logic [2:0]       reg_write,
  output logic [15:0]      write_data,
  output logic [2:0]       reg_read1,
  output logic [2:0]       reg_read2,
  output logic             size,
  output logic             select_high_low,
  input  logic [15:0]      read_data1,
  input  logic [15:0]      read_data2,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [2:0]         reg_write_q, reg_write_d;
  logic [15:0]        write_data_q, write_data_d;
  logic [2:0]         reg_read1_q, reg_read1_d;
  logic [2:0]         reg_read2_q, reg_read2_d;
  logic               size_q, size_d;
  logic               sel_q, sel_d;
  logic               rd_hi2_q, rd_hi2_d;
  logic               rsp_write_q, rsp_write_d;
  logic [15:0]        rsp_data1_q, rsp_data1_d;
  logic [15:0]        rsp_data2_q, rsp_data2_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;

  logic [2:0] wr_idx, rd1_idx, rd2_idx;
  logic       wr_sel, rd1_sel, rd2_sel;

  reg8088_byte_decode u_dec_wr (
    .code            (req_reg),
    .size            (req_size),
    .index           (wr_idx),
    .select_high_low (wr_sel)
  );

  reg8088_byte_decode u_dec_rd1 (
    .code            (req_reg),
    .size            (req_size),
    .index           (rd1_idx),
    .select_high_low (rd1_sel)
  );

  reg8088_byte_decode u_dec_rd2 (
    .code            (req_reg2),
    .size            (req_size),
    .index           (rd2_idx),
    .select_high_low (rd2_sel)
  );

  // Next-state and registered-output logic; bank ports are loaded at request
  // acceptance so they are stable for the whole WRITE/READ cycle
  always_comb begin
    state_d      = state_q;
    reg_write_d  = reg_write_q;
    write_data_d = write_data_q;
    reg_read1_d  = reg_read1_q;
    reg_read2_d  = reg_read2_q;
    size_d       = size_q;
    sel_d        = sel_q;
    rd_hi2_d     = rd_hi2_q;
    rsp_write_d  = rsp_write_q;
    rsp_data1_d  = rsp_data1_q;
    rsp_data2_d  = rsp_data2_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          if (req_write) begin
            state_d      = ST_WRITE;
            reg_write_d  = wr_idx;
            sel_d        = wr_sel;
            write_data_d = (req_size == SIZE_16) ? req_wdata
                                                 : {req_wdata[7:0], req_wdata[7:0]};
          end else begin
            state_d     = ST_READ;
            reg_read1_d = rd1_idx;
            reg_read2_d = rd2_idx;
            sel_d       = rd1_sel;
            rd_hi2_d    = rd2_sel;
          end
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_write_d = 1'b1;
        rsp_data1_d = 16'h0000;
        rsp_data2_d = 16'h0000;
        wr_count_d  = wr_count_q + CNT_W'(1);
      end
      ST_READ: begin
        state_d     = ST_RESP;
        rsp_write_d = 1'b0;
        rsp_data1_d = (size_q == SIZE_16) ? read_data1 : extract_byte(read_data1, sel_q);
        rsp_data2_d = (size_q == SIZE_16) ? read_data2 : extract_byte(read_data2, rd_hi2_q);
        rd_count_d  = rd_count_q + CNT_W'(1);
      end
      default: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      reg_write_q  <= '0;
      write_data_q <= '0;
      reg_read1_q  <= '0;
      reg_read2_q  <= '0;
      size_q       <= 1'b0;
      sel_q        <= 1'b0;
      rd_hi2_q     <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_data1_q  <= '0;
      rsp_data2_q  <= '0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      write_data_q <= write_data_d;
      reg_read1_q  <= reg_read1_d;
      reg_read2_q  <= reg_read2_d;
      size_q       <= size_d;
      sel_q        <= sel_d;
      rd_hi2_q     <= rd_hi2_d;
      rsp_write_q  <= rsp_write_d;
      rsp_data1_q  <= rsp_data1_d;
      rsp_data2_q  <= rsp_data2_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  // Handshake/enable strobes are pure state decodes so reset clears them at once
  assign req_ready       = (state_q == ST_IDLE);
  assign rsp_valid       = (state_q == ST_RESP);
  assign en_write        = (state_q == ST_WRITE);
  assign rsp_write       = rsp_write_q;
  assign rsp_data1       = rsp_data1_q;
  assign rsp_data2       = rsp_data2_q;
  assign reg_write       = reg_write_q;
  assign write_data      = write_data_q;
  assign reg_read1       = reg_read1_q;
  assign reg_read2       = reg_read2_q;
  assign size            = size_q;
  assign select_high_low = sel_q;
  assign wr_count        = wr_count_q;
  assign rd_count        = rd_count_q;

endmodule

// File: tb/tb_reg_bank_access_ctrl.sv
// Directed + table-driven bench for reg_bank_access_ctrl with a bank model.
module tb_reg_bank_access_ctrl;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic             req_size = 1'b0;
  logic [2:0]       req_reg = '0;
  logic [2:0]       req_reg2 = '0;
  logic [15:0]      req_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_write;
  logic [15:0]      rsp_data1, rsp_data2;
  logic             en_write;
  logic [2:0]       reg_write;
  logic [15:0]      write_data;
  logic [2:0]       reg_read1, reg_read2;
  logic             size;
  logic             select_high_low;
  logic [15:0]      read_data1, read_data2;
  logic [CNT_W-1:0] wr_count, rd_count;

  reg_bank_access_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_reg         (req_reg),
    .req_reg2        (req_reg2),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_write       (rsp_write),
    .rsp_data1       (rsp_data1),
    .rsp_data2       (rsp_data2),
    .en_write        (en_write),
    .reg_write       (reg_write),
    .write_data      (write_data),
    .reg_read1       (reg_read1),
    .reg_read2       (reg_read2),
    .size            (size),
    .select_high_low (select_high_low),
    .read_data1      (read_data1),
    .read_data2      (read_data2),
    .wr_count        (wr_count),
    .rd_count        (rd_count)
  );

  always #5 clk = ~clk;

  // Bank model: 8 x 16-bit, combinational read, byte-lane write
  logic        bank_clr = 1'b1;
  logic [15:0] bank [8];
  int          en_pulses = 0;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 16'h0000;
    end else if (en_write) begin
      if (size) bank[reg_write] <= write_data;
      else if (select_high_low) bank[reg_write][15:8] <= write_data[15:8];
      else bank[reg_write][7:0] <= write_data[7:0];
    end
  end

  always @(posedge clk) if (en_write === 1'b1) en_pulses++;

  assign read_data1 = bank[reg_read1];
  assign read_data2 = bank[reg_read2];

  int checks = 0;
  int errors = 0;

  // Reference register file and access counters
  logic [15:0]      ref_regs [8];
  logic [CNT_W-1:0] wr_m = '0;
  logic [CNT_W-1:0] rd_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_apply(input logic w, input logic s, input logic [2:0] r, input logic [15:0] wd);
    logic [2:0] idx;
    idx = s ? r : {1'b0, r[1:0]};
    if (w) begin
      if (s) ref_regs[idx] = wd;
      else if (r[2]) ref_regs[idx][15:8] = wd[7:0];
      else ref_regs[idx][7:0] = wd[7:0];
      wr_m = wr_m + CNT_W'(1);
    end else begin
      rd_m = rd_m + CNT_W'(1);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic s, input logic [2:0] r);
    logic [2:0] idx;
    idx = s ? r : {1'b0, r[1:0]};
    if (s) return ref_regs[idx];
    return r[2] ? {8'h00, ref_regs[idx][15:8]} : {8'h00, ref_regs[idx][7:0]};
  endfunction

  // One full request/response transaction with rsp_ready held high
  task automatic xact(input logic w, input logic s, input logic [2:0] r, input logic [2:0] r2,
                      input logic [15:0] wd, output logic [15:0] d1, output logic [15:0] d2,
                      output logic rw, output logic c_en, output logic [2:0] c_idx,
                      output logic [15:0] c_wd, output logic c_sel, output bit ok);
    int n;
    ok = 0; d1 = '0; d2 = '0; rw = 1'b0; c_en = 1'b0; c_idx = '0; c_wd = '0; c_sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = s; req_reg = r; req_reg2 = r2;
    req_wdata = wd; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      req_valid = 1'b0;
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    c_en = en_write; c_idx = reg_write; c_wd = write_data; c_sel = select_high_low;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) begin
      chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
      return;
    end
    d1 = rsp_data1; d2 = rsp_data2; rw = rsp_write;
    @(posedge clk);
    #1;
    ref_apply(w, s, r, wd);
    ok = 1;
  endtask

  typedef struct {
    logic        w;
    logic        s;
    logic [2:0]  r;
    logic [2:0]  r2;
    logic [15:0] wd;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t tbl [13];

  initial begin : main
    logic [15:0] d1, d2, h1, h2;
    logic        rw, c_en, c_sel;
    logic [2:0]  c_idx;
    logic [15:0] c_wd;
    bit          ok;
    int          en_base, wr_n;
    logic [CNT_W-1:0] wrap_exp [5];

    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;

    tbl[0]  = '{1'b1, 1'b1, 3'd0, 3'd0, 16'h1234, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 3'd0, 3'd0, 16'h0000, 16'h1234, 16'h1234};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 3'd0, 16'h00AB, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 3'd4, 3'd0, 16'h0000, 16'h00AB, 16'h0034};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 3'd0, 16'h0000, 16'hAB34, 16'hAB34};
    tbl[5]  = '{1'b1, 1'b1, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 3'd3, 3'd7, 16'h0000, 16'h00EF, 16'h00BE};
    tbl[7]  = '{1'b1, 1'b0, 3'd1, 3'd0, 16'h995A, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 3'd1, 3'd3, 16'h0000, 16'h005A, 16'hBEEF};
    tbl[9]  = '{1'b1, 1'b0, 3'd6, 3'd0, 16'hFF77, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 3'd6, 3'd2, 16'h0000, 16'h0077, 16'h0000};
    tbl[11] = '{1'b1, 1'b1, 3'd7, 3'd0, 16'hCAFE, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 3'd7, 3'd2, 16'h0000, 16'hCAFE, 16'h7700};

    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_en_write", {31'd0, en_write}, 32'd0);
    chk("rst_rsp_data1", {16'd0, rsp_data1}, 32'd0);
    chk("rst_counts", {28'd0, wr_count, rd_count}, 32'd0);
    bank_clr = 1'b0;
    reset = 1'b1;

    // Reset asserted in the middle of a WRITE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_reg = 3'd0; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 chk("midwr_en_before", {31'd0, en_write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midwr_en_drop", {31'd0, en_write}, 32'd0);
    chk("midwr_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("midwr_bank_ax", {16'd0, bank[0]}, 32'd0);
    chk("midwr_counts", {28'd0, wr_count, rd_count}, 32'd0);
    reset = 1'b1;

    // Counter wrap with CNT_W = 2
    for (int i = 0; i < 5; i++) begin
      xact(1'b1, 1'b1, 3'd5, 3'd0, 16'h1000 + 16'(i), d1, d2, rw, c_en, c_idx, c_wd, c_sel, ok);
      chk($sformatf("wrap_wr_count_%0d", i), {30'd0, wr_count}, {30'd0, wrap_exp[i]});
    end

    // Table-driven directed vectors
    for (int i = 0; i < 13; i++) begin
      xact(tbl[i].w, tbl[i].s, tbl[i].r, tbl[i].r2, tbl[i].wd, d1, d2, rw, c_en, c_idx, c_wd, c_sel, ok);
      if (ok) begin
        chk($sformatf("tbl%0d_rsp_write", i), {31'd0, rw}, {31'd0, tbl[i].w});
        chk($sformatf("tbl%0d_data1", i), {16'd0, d1}, {16'd0, tbl[i].e1});
        chk($sformatf("tbl%0d_data2", i), {16'd0, d2}, {16'd0, tbl[i].e2});
        chk($sformatf("tbl%0d_counts", i), {28'd0, wr_count, rd_count}, {28'd0, wr_m, rd_m});
        if (tbl[i].w) begin
          chk($sformatf("tbl%0d_en_write", i), {31'd0, c_en}, 32'd1);
          chk($sformatf("tbl%0d_reg_write", i), {29'd0, c_idx},
              {29'd0, (tbl[i].s ? tbl[i].r : {1'b0, tbl[i].r[1:0]})});
          chk($sformatf("tbl%0d_write_data", i), {16'd0, c_wd},
              {16'd0, (tbl[i].s ? tbl[i].wd : {tbl[i].wd[7:0], tbl[i].wd[7:0]})});
          chk($sformatf("tbl%0d_sel", i), {31'd0, c_sel}, {31'd0, (tbl[i].s ? 1'b0 : tbl[i].r[2])});
        end
      end
    end

    // Response backpressure with a competing request held valid
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_reg = 3'd0; req_reg2 = 3'd3;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    ref_apply(1'b0, 1'b1, 3'd0, 16'h0);
    req_reg = 3'd2; req_reg2 = 3'd1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid_first", {31'd0, rsp_valid}, 32'd1);
    h1 = rsp_data1; h2 = rsp_data2;
    chk("bp_data1", {16'd0, h1}, 32'h0000AB34);
    chk("bp_data2", {16'd0, h2}, 32'h0000BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {14'd0, rsp_valid, req_ready, rsp_data1 ^ h1},
          {14'd0, 1'b1, 1'b0, 16'h0000});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(negedge clk);
    chk("bp_new_accepted", {30'd0, rsp_valid, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_new_data1", {16'd0, rsp_data1}, 32'h00007700);
    chk("bp_new_data2", {16'd0, rsp_data2}, 32'h0000005A);
    @(posedge clk);
    #1;
    ref_apply(1'b0, 1'b1, 3'd2, 16'h0);
    chk("bp_counts", {28'd0, wr_count, rd_count}, {28'd0, wr_m, rd_m});

    // Randomized stream against the reference register file
    en_base = en_pulses;
    wr_n = 0;
    for (int i = 0; i < 200; i++) begin
      logic        w, s;
      logic [2:0]  r, r2;
      logic [15:0] wd, e1, e2;
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      r  = 3'($urandom_range(0, 7));
      r2 = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      e1 = w ? 16'h0000 : ref_read(s, r);
      e2 = w ? 16'h0000 : ref_read(s, r2);
      if (w) wr_n++;
      xact(w, s, r, r2, wd, d1, d2, rw, c_en, c_idx, c_wd, c_sel, ok);
      if (ok) begin
        if ({rw, d1, d2} !== {w, e1, e2})
          chk($sformatf("rand%0d_rsp", i), {15'd0, rw, d1 ^ e1}, {15'd0, w, 16'h0000});
        else
          chk($sformatf("rand%0d_rsp", i), {16'd0, d2}, {16'd0, e2});
      end
    end
    chk("rand_en_pulses", 32'(en_pulses - en_base), 32'(wr_n));
    chk("rand_counts", {28'd0, wr_count, rd_count}, {28'd0, wr_m, rd_m});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
